// File: rtl/ts_pkg.sv
// Shared MPEG2-TS definitions used by the packet synchronizer and the loss counter.
package ts_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_t;

endpackage

// File: rtl/ts_packet_sync.sv
// Per-stream TS packet synchronizer: hunts for the sync byte, verifies it over
// several packets, then forwards aligned bytes with a strobe on each packet start.
module ts_packet_sync
  import ts_pkg::*;
#(
  parameter int         PKT_LEN    = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic        out_sync,
  output logic [7:0]  out_data,
  output logic        locked,
  output logic [15:0] sync_loss_count
);

  localparam int POS_W = $clog2(PKT_LEN);
  localparam int CNT_W = $clog2(((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT) + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PKT_LEN - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_CNT);

  sync_state_t      state, state_next;
  logic [POS_W-1:0] pos, pos_next, pos_inc;
  logic [CNT_W-1:0] good, good_next;
  logic [CNT_W-1:0] miss, miss_next;
  logic [15:0]      loss_next;
  logic             valid_next, sync_next, locked_next;
  logic [7:0]       data_next;
  logic             is_sync;

  assign pos_inc = (pos == POS_LAST) ? '0 : pos + POS_ONE;
  assign is_sync = (in_data == SYNC_BYTE);

  // Next-state and next-output logic; idle cycles hold all state and drop out_valid.
  always_comb begin
    state_next = state;
    pos_next   = pos;
    good_next  = good;
    miss_next  = miss;
    loss_next  = sync_loss_count;
    valid_next = 1'b0;
    sync_next  = 1'b0;
    data_next  = out_data;
    if (in_valid) begin
      data_next = in_data;
      unique case (state)
        HUNT: begin
          if (is_sync) begin
            good_next = CNT_ONE;
            pos_next  = pos_inc;
            if (LOCK_N == CNT_ONE) begin
              state_next = LOCK;
              miss_next  = '0;
              valid_next = 1'b1;
              sync_next  = 1'b1;
            end else begin
              state_next = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (pos == '0) begin
            if (is_sync) begin
              good_next = good + CNT_ONE;
              pos_next  = pos_inc;
              if (good + CNT_ONE == LOCK_N) begin
                state_next = LOCK;
                miss_next  = '0;
                valid_next = 1'b1;
                sync_next  = 1'b1;
              end
            end else begin
              state_next = HUNT;
              pos_next   = '0;
              good_next  = '0;
            end
          end else begin
            pos_next = pos_inc;
          end
        end
        LOCK: begin
          pos_next   = pos_inc;
          valid_next = 1'b1;
          sync_next  = (pos == '0);
          if (pos == '0) begin
            if (is_sync) begin
              miss_next = '0;
            end else if (miss + CNT_ONE == UNLOCK_N) begin
              valid_next = 1'b0;
              sync_next  = 1'b0;
              state_next = HUNT;
              pos_next   = '0;
              good_next  = '0;
              miss_next  = '0;
              loss_next  = (sync_loss_count == 16'hFFFF) ? sync_loss_count
                                                         : sync_loss_count + 16'd1;
            end else begin
              miss_next = miss + CNT_ONE;
            end
          end
        end
        default: begin
          state_next = HUNT;
          pos_next   = '0;
          good_next  = '0;
          miss_next  = '0;
        end
      endcase
    end
  end

  assign locked_next = (state_next == LOCK);

  // State, counters and registered outputs; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT;
      pos             <= '0;
      good            <= '0;
      miss            <= '0;
      sync_loss_count <= '0;
      out_valid       <= 1'b0;
      out_sync        <= 1'b0;
      out_data        <= '0;
      locked          <= 1'b0;
    end else begin
      state           <= state_next;
      pos             <= pos_next;
      good            <= good_next;
      miss            <= miss_next;
      sync_loss_count <= loss_next;
      out_valid       <= valid_next;
      out_sync        <= sync_next;
      out_data        <= data_next;
      locked          <= locked_next;
    end
  end

endmodule
